// File: rtl/sprite_controller.sv
// sprite_controller: moves one sprite with buttons at a divided rate and produces registered pixel colour.
module sprite_controller #(
    parameter int H_MIN = 144,
    parameter int H_MAX = 783,
    parameter int V_MIN = 35,
    parameter int V_MAX = 515,
    parameter int HALF_W = 5,
    parameter int HALF_H = 5,
    parameter int STEP = 2,
    parameter int TICK_DIV = 1,
    parameter int X_INIT = 450,
    parameter int Y_INIT = 250,
    parameter int EDGE_MODE = 0,
    parameter logic [11:0] COLOR = 12'hF00,
    parameter logic [11:0] BG_INIT = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bright,
    input  logic        left,
    input  logic        right,
    input  logic        up,
    input  logic        down,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    output logic [11:0] rgb,
    output logic [11:0] background,
    output logic [9:0]  xpos,
    output logic [9:0]  ypos,
    output logic        move_tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    // landing spots when a step would cross an edge: opposite edge (wrap) or same edge (clamp)
    localparam logic [9:0] X_HI = EDGE_MODE != 0 ? 10'(H_MAX) : 10'(H_MIN);
    localparam logic [9:0] X_LO = EDGE_MODE != 0 ? 10'(H_MIN) : 10'(H_MAX);
    localparam logic [9:0] Y_HI = EDGE_MODE != 0 ? 10'(V_MAX) : 10'(V_MIN);
    localparam logic [9:0] Y_LO = EDGE_MODE != 0 ? 10'(V_MIN) : 10'(V_MAX);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;
    logic [9:0]    x_q, x_d, y_q, y_d;
    logic [11:0]   bg_q, bg_d, rgb_q, rgb_d;
    logic [10:0]   xw, yw, xp, xm, yp, ym, hw, vw;
    logic          fill;
    always_comb begin
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        xw = {1'b0, x_q};
        yw = {1'b0, y_q};
        hw = {1'b0, hCount};
        vw = {1'b0, vCount};
        xp = xw + 11'(STEP);
        xm = xw - 11'(STEP);
        yp = yw + 11'(STEP);
        ym = yw - 11'(STEP);
        x_d = right ? (xp > 11'(H_MAX) ? X_HI : xp[9:0]) :
              left  ? (xw < 11'(H_MIN + STEP) ? X_LO : xm[9:0]) : x_q;
        y_d = down  ? (yp > 11'(V_MAX) ? Y_HI : yp[9:0]) :
              up    ? (yw < 11'(V_MIN + STEP) ? Y_LO : ym[9:0]) : y_q;
        fill = (hw + 11'(HALF_W) >= xw) && (hw <= xw + 11'(HALF_W)) &&
               (vw + 11'(HALF_H) >= yw) && (vw <= yw + 11'(HALF_H));
        rgb_d = !bright ? 12'h000 : fill ? COLOR : bg_q;
        bg_d = right ? 12'h0F0 : left ? 12'h00F : down ? 12'hFF0 : up ? 12'h0FF : bg_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            x_q    <= 10'(X_INIT);
            y_q    <= 10'(Y_INIT);
            bg_q   <= BG_INIT;
            rgb_q  <= 12'h000;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= cnt_d == LAST;
            if (tick_q) begin
                x_q <= x_d;
                y_q <= y_d;
            end
            bg_q  <= bg_d;
            rgb_q <= rgb_d;
        end
    end
    assign rgb        = rgb_q;
    assign background = bg_q;
    assign xpos       = x_q;
    assign ypos       = y_q;
    assign move_tick  = tick_q;
endmodule

// File: tb/tb_sprite_controller.sv
// tb_sprite_controller: vector table, edge sequences and random run against a cycle-count reference model.
module tb_sprite_controller;
    logic clk = 1'b0;
    logic rst, bright, left, right, up, down;
    logic [9:0] hCount, vCount;
    logic [11:0] rgb_o [3];
    logic [11:0] bg_o [3];
    logic [9:0] x_o [3];
    logic [9:0] y_o [3];
    logic tk_o [3];
    int n_chk = 0;
    int n_fail = 0;
    int mx [3], my [3], mbg [3], mrgb [3], mtk [3], mn [3];

    always #5 clk = ~clk;

    sprite_controller #(.TICK_DIV(4), .EDGE_MODE(0)) d0 (.clk(clk), .rst(rst), .bright(bright),
        .left(left), .right(right), .up(up), .down(down), .hCount(hCount), .vCount(vCount),
        .rgb(rgb_o[0]), .background(bg_o[0]), .xpos(x_o[0]), .ypos(y_o[0]), .move_tick(tk_o[0]));
    sprite_controller #(.TICK_DIV(1), .EDGE_MODE(1)) d1 (.clk(clk), .rst(rst), .bright(bright),
        .left(left), .right(right), .up(up), .down(down), .hCount(hCount), .vCount(vCount),
        .rgb(rgb_o[1]), .background(bg_o[1]), .xpos(x_o[1]), .ypos(y_o[1]), .move_tick(tk_o[1]));
    sprite_controller #(.TICK_DIV(1), .EDGE_MODE(0)) d2 (.clk(clk), .rst(rst), .bright(bright),
        .left(left), .right(right), .up(up), .down(down), .hCount(hCount), .vCount(vCount),
        .rgb(rgb_o[2]), .background(bg_o[2]), .xpos(x_o[2]), .ypos(y_o[2]), .move_tick(tk_o[2]));

    typedef struct {
        bit rst; bit [3:0] b; bit br; int h; int v;
        int ex; int ey; int ebg; int ergb; int etk;
    } vec_t;
    vec_t tv [19];

    function automatic vec_t mk(bit r, bit [3:0] b, bit br, int h, int v,
                                int ex, int ey, int ebg, int ergb, int etk);
        vec_t t;
        t.rst = r; t.b = b; t.br = br; t.h = h; t.v = v;
        t.ex = ex; t.ey = ey; t.ebg = ebg; t.ergb = ergb; t.etk = etk;
        return t;
    endfunction

    function automatic int mv(int p, bit inc, int lo, int hi, bit clamp);
        if (inc) return p + 2 > hi ? (clamp ? hi : lo) : p + 2;
        return p < lo + 2 ? (clamp ? lo : hi) : p - 2;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // b = {right, left, down, up}
    task automatic drive(bit r, bit [3:0] b, bit br, int h, int v);
        rst = r; right = b[3]; left = b[2]; down = b[1]; up = b[0];
        bright = br; hCount = 10'(h); vCount = 10'(v);
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mx[i] = 450; my[i] = 250; mbg[i] = 'hFFF; mrgb[i] = 0; mtk[i] = 0; mn[i] = 0;
            end else begin
                mrgb[i] = !bright ? 0 :
                    (int'(hCount) + 5 >= mx[i] && int'(hCount) <= mx[i] + 5 &&
                     int'(vCount) + 5 >= my[i] && int'(vCount) <= my[i] + 5) ? 'hF00 : mbg[i];
                if (mtk[i] != 0) begin
                    if (right) mx[i] = mv(mx[i], 1, 144, 783, i == 1);
                    else if (left) mx[i] = mv(mx[i], 0, 144, 783, i == 1);
                    if (down) my[i] = mv(my[i], 1, 35, 515, i == 1);
                    else if (up) my[i] = mv(my[i], 0, 35, 515, i == 1);
                end
                mbg[i] = right ? 'h0F0 : left ? 'h00F : down ? 'hFF0 : up ? 'h0FF : mbg[i];
                mn[i]++;
                mtk[i] = ((mn[i] + 1) % (i == 0 ? 4 : 1)) == 0 ? 1 : 0;
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_x%0d", i), int'(x_o[i]), mx[i]);
            chk($sformatf("model_y%0d", i), int'(y_o[i]), my[i]);
            chk($sformatf("model_bg%0d", i), int'(bg_o[i]), mbg[i]);
            chk($sformatf("model_rgb%0d", i), int'(rgb_o[i]), mrgb[i]);
            chk($sformatf("model_tick%0d", i), int'(tk_o[i]), mtk[i]);
        end
    endtask

    task automatic do_reset();
        drive(1, 4'b0000, 0, 0, 0);
        step();
        step();
    endtask

    initial begin
        int guard;
        int cx;
        int cy;
        drive(1, 4'b0000, 0, 0, 0);
        tv[0]  = mk(1, 4'b0000, 0, 0, 0, 450, 250, 'hFFF, 0, 0);
        tv[1]  = mk(1, 4'b0000, 0, 0, 0, 450, 250, 'hFFF, 0, 0);
        tv[2]  = mk(0, 4'b0000, 0, 0, 0, 450, 250, 'hFFF, 0, 0);
        tv[3]  = mk(0, 4'b1000, 0, 0, 0, 450, 250, 'h0F0, 0, 0);
        tv[4]  = mk(0, 4'b1000, 0, 0, 0, 450, 250, 'h0F0, 0, 1);
        tv[5]  = mk(0, 4'b1000, 0, 0, 0, 452, 250, 'h0F0, 0, 0);
        tv[6]  = mk(0, 4'b1000, 0, 0, 0, 452, 250, 'h0F0, 0, 0);
        tv[7]  = mk(0, 4'b1000, 0, 0, 0, 452, 250, 'h0F0, 0, 0);
        tv[8]  = mk(0, 4'b1000, 0, 0, 0, 452, 250, 'h0F0, 0, 1);
        tv[9]  = mk(0, 4'b1101, 0, 0, 0, 454, 248, 'h0F0, 0, 0);
        tv[10] = mk(0, 4'b0000, 0, 0, 0, 454, 248, 'h0F0, 0, 0);
        tv[11] = mk(0, 4'b0000, 1, 449, 253, 454, 248, 'h0F0, 'hF00, 0);
        tv[12] = mk(0, 4'b0000, 1, 448, 253, 454, 248, 'h0F0, 'h0F0, 1);
        tv[13] = mk(0, 4'b0000, 0, 449, 253, 454, 248, 'h0F0, 0, 0);
        tv[14] = mk(0, 4'b0000, 1, 459, 243, 454, 248, 'h0F0, 'hF00, 0);
        tv[15] = mk(0, 4'b0000, 1, 460, 243, 454, 248, 'h0F0, 'h0F0, 0);
        tv[16] = mk(0, 4'b0010, 0, 0, 0, 454, 248, 'hFF0, 0, 1);
        tv[17] = mk(0, 4'b0001, 1, 454, 248, 454, 246, 'h0FF, 'hF00, 0);
        tv[18] = mk(0, 4'b0011, 1, 454, 240, 454, 246, 'hFF0, 'h0FF, 0);
        for (int r = 0; r < 19; r++) begin
            drive(tv[r].rst, tv[r].b, tv[r].br, tv[r].h, tv[r].v);
            step();
            chk($sformatf("vec%0d_x", r), int'(x_o[0]), tv[r].ex);
            chk($sformatf("vec%0d_y", r), int'(y_o[0]), tv[r].ey);
            chk($sformatf("vec%0d_bg", r), int'(bg_o[0]), tv[r].ebg);
            chk($sformatf("vec%0d_rgb", r), int'(rgb_o[0]), tv[r].ergb);
            chk($sformatf("vec%0d_tick", r), int'(tk_o[0]), tv[r].etk);
        end

        do_reset();
        drive(0, 4'b1000, 0, 0, 0);
        guard = 0;
        while (mx[2] != 782 && guard < 400) begin step(); guard++; end
        chk("reach_x782", mx[2], 782);
        step();
        chk("wrap_right_x", int'(x_o[2]), 144);
        chk("clamp_right_x", int'(x_o[1]), 783);
        step();
        chk("wrap_right_x2", int'(x_o[2]), 146);
        chk("clamp_hold_x", int'(x_o[1]), 783);
        drive(0, 4'b0000, 0, 0, 0);
        step();
        do_reset();
        drive(0, 4'b1000, 0, 0, 0);
        guard = 0;
        while (mx[2] != 782 && guard < 400) begin step(); guard++; end
        step();
        drive(0, 4'b0100, 0, 0, 0);
        step();
        chk("wrap_left_x", int'(x_o[2]), 783);
        chk("clamp_left_x", int'(x_o[1]), 781);
        drive(0, 4'b0001, 0, 0, 0);
        guard = 0;
        while (my[1] != 36 && guard < 400) begin step(); guard++; end
        chk("reach_y36", my[1], 36);
        step();
        chk("clamp_up_y", int'(y_o[1]), 35);
        chk("wrap_up_y", int'(y_o[2]), 515);
        drive(0, 4'b0010, 0, 0, 0);
        step();
        chk("wrap_down_y", int'(y_o[2]), 35);
        chk("clamp_down_y", int'(y_o[1]), 37);

        do_reset();
        drive(0, 4'b0010, 0, 0, 0);
        for (int k = 0; k < 4; k++) step();
        chk("midmove_y", int'(y_o[1]), 256);
        drive(1, 4'b0010, 0, 0, 0);
        step();
        chk("midrst_y1", int'(y_o[1]), 250);
        chk("midrst_y2", int'(y_o[2]), 250);
        chk("midrst_bg", int'(bg_o[1]), 'hFFF);
        chk("midrst_tick", int'(tk_o[1]), 0);

        for (int k = 0; k < 3000; k++) begin
            cx = mx[k % 3] + $urandom_range(0, 16) - 8;
            cy = my[k % 3] + $urandom_range(0, 16) - 8;
            drive($urandom_range(0, 63) == 0, 4'($urandom), $urandom_range(0, 3) != 0, cx, cy);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
